sha256_round_ctrl: RTL and testbench

//  Sequencer for the SHA-256 compression datapath: drives load/start enables of the working

---
 rtl/sha256_ctrl_pkg.sv | 15 +
 rtl/sha256_round_cnt.sv | 39 +++
 rtl/sha256_round_ctrl.sv | 115 +++++++++++
 tb/tb_sha256_round_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_ctrl_pkg.sv
// rtl/sha256_ctrl_pkg.sv - shared state encoding and defaults for the SHA-256 round sequencer
package sha256_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        UPDATE,
        DONE
    } state_e;

    localparam int ROUNDS_DEF    = 64;
    localparam int MSG_WORDS_DEF = 16;

endpackage

// File: rtl/sha256_round_cnt.sv
// rtl/sha256_round_cnt.sv - round index counter with enable, clear and terminal-count flag
module sha256_round_cnt #(
    parameter int IDX_W  = 6,
    parameter int ROUNDS = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             clr,
    output logic [IDX_W-1:0] cnt,
    output logic             tc
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(ROUNDS - 1);

    logic [IDX_W-1:0] cnt_q, cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == LAST);

    // Wraps to zero on the final round so the index never exceeds ROUNDS-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : cnt_q + IDX_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// rtl/sha256_round_ctrl.sv - SHA-256 compression sequencer; optional STALL_EN adds rnd_stall
module sha256_round_ctrl
    import sha256_ctrl_pkg::*;
#(
    parameter int ROUNDS    = ROUNDS_DEF,
    parameter int IDX_W     = 6,
    parameter int MSG_WORDS = MSG_WORDS_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             blk_valid,
    input  logic             blk_last,
    output logic             blk_ready,
    output logic             ld_work,
    output logic             iv_sel,
    output logic             rnd_en,
    output logic [IDX_W-1:0] rnd_idx,
    output logic             w_sel,
`ifdef STALL_EN
    input  logic             rnd_stall,
`endif
    output logic             hash_upd,
    output logic             digest_valid,
    input  logic             digest_ready,
    output logic             busy
);

    localparam logic [IDX_W:0] MSG_LIM = (IDX_W + 1)'(MSG_WORDS);

    state_e state_q, state_d;
    logic   first_q, first_d;
    logic   last_q, last_d;
    logic   stall;
    logic   adv;
    logic   tc;

`ifdef STALL_EN
    assign stall = rnd_stall;
`else
    assign stall = 1'b0;
`endif

    assign adv = (state_q == ROUND) && !stall;

    sha256_round_cnt #(
        .IDX_W  (IDX_W),
        .ROUNDS (ROUNDS)
    ) u_cnt (
        .CLK (CLK),
        .RST (RST),
        .en  (adv),
        .clr (clr),
        .cnt (rnd_idx),
        .tc  (tc)
    );

    assign blk_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign ld_work      = (state_q == LOAD);
    assign iv_sel       = (state_q == LOAD) && first_q;
    assign rnd_en       = adv;
    assign w_sel        = (state_q == ROUND) && ({1'b0, rnd_idx} < MSG_LIM);
    assign hash_upd     = (state_q == UPDATE);
    assign digest_valid = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    last_d  = blk_last;
                    state_d = LOAD;
                end
            end
            LOAD:   state_d = ROUND;
            ROUND: begin
                if (adv && tc) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                first_d = 1'b0;
                state_d = last_q ? DONE : IDLE;
            end
            DONE: begin
                if (digest_ready) begin
                    first_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Soft abort overrides everything, including a same-cycle accept.
        if (clr) begin
            state_d = IDLE;
            first_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            first_q <= 1'b1;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb/tb_sha256_round_ctrl.sv - randomized and directed bench for sha256_round_ctrl
module tb_sha256_round_ctrl;

    localparam int R  = 64;
    localparam int MW = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic       clr, blk_valid, blk_last, digest_ready;
    logic       blk_ready, ld_work, iv_sel, rnd_en, w_sel, hash_upd, digest_valid, busy;
    logic [5:0] rnd_idx;
`ifdef STALL_EN
    logic       rnd_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Timeline model: ph=0 idle, 1 load, 2..R+1 round (ph-2), R+2 update, R+3 done.
    int ph      = 0;
    bit m_first = 1'b1;
    bit m_last  = 1'b0;

    always #5 CLK = ~CLK;

    sha256_round_ctrl dut (
        .CLK          (CLK),
        .RST          (RST),
        .clr          (clr),
        .blk_valid    (blk_valid),
        .blk_last     (blk_last),
        .blk_ready    (blk_ready),
        .ld_work      (ld_work),
        .iv_sel       (iv_sel),
        .rnd_en       (rnd_en),
        .rnd_idx      (rnd_idx),
        .w_sel        (w_sel),
`ifdef STALL_EN
        .rnd_stall    (rnd_stall),
`endif
        .hash_upd     (hash_upd),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outs(input bit s);
        bit         in_round;
        int         idx;
        logic [7:0] exp_v, obs_v;
        in_round = (ph >= 2) && (ph <= R + 1);
        idx      = in_round ? ph - 2 : 0;
        exp_v = {ph == 0, ph != 0, ph == 1, (ph == 1) && m_first,
                 in_round && !s, in_round && (idx < MW), ph == R + 2, ph == R + 3};
        obs_v = {blk_ready, busy, ld_work, iv_sel, rnd_en, w_sel, hash_upd, digest_valid};
        check_eq("ctl_outs", {24'd0, obs_v}, {24'd0, exp_v});
        check_eq("rnd_idx", {26'd0, rnd_idx}, idx);
    endtask

    task automatic model_step(input bit v, input bit l, input bit dr, input bit c, input bit s);
        if (c) begin
            ph      = 0;
            m_first = 1'b1;
        end else if (ph == 0) begin
            if (v) begin
                ph     = 1;
                m_last = l;
            end
        end else if (ph == 1) begin
            ph = 2;
        end else if (ph <= R + 1) begin
            if (!s) ph = ph + 1;
        end else if (ph == R + 2) begin
            m_first = 1'b0;
            ph      = m_last ? R + 3 : 0;
        end else if (dr) begin
            m_first = 1'b1;
            ph      = 0;
        end
    endtask

    task automatic cyc(input bit v, input bit l, input bit dr, input bit c, input bit s);
        blk_valid    = v;
        blk_last     = l;
        digest_ready = dr;
        clr          = c;
`ifdef STALL_EN
        rnd_stall    = s;
`endif
        #1;
        check_outs(s);
        model_step(v, l, dr, c, s);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_to_idx(input int target);
        int n;
        n = 0;
        while (rnd_idx != target[5:0] && n < 200) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        check_eq("idx_reach_timeout", n < 200, 1);
    endtask

    task automatic run_to_idle(input bit v, input bit l);
        int n;
        n = 0;
        while (ph != 0 && n < 300) begin
            cyc(v, l, 1, 0, 0);
            n++;
        end
        check_eq("idle_timeout", n < 300, 1);
    endtask

    initial begin
        int n;
        RST = 1'b0; clr = 0; blk_valid = 0; blk_last = 0; digest_ready = 0;
`ifdef STALL_EN
        rnd_stall = 0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        check_outs(0);
        RST = 1'b1;

        // Single-block message with latency measurement
        cyc(1, 1, 0, 0, 0);
        n = 0;
        while (hash_upd !== 1'b1 && n < 200) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        check_eq("lat_hash_upd", n, R + 1);
        cyc(0, 0, 0, 0, 0);
        check_eq("digest_valid", digest_valid, 1);
        repeat (10) cyc(1, 0, 0, 0, 0);
        check_eq("done_hold_ready", blk_ready, 0);
        check_eq("done_hold_valid", digest_valid, 1);
        cyc(0, 0, 1, 0, 0);
        check_eq("done_release", blk_ready, 1);

        // Two-block message, blk_valid held throughout
        cyc(1, 0, 0, 0, 0);
        check_eq("blk1_iv_sel", iv_sel, 1);
        run_to_idle(1, 0);
        cyc(1, 1, 0, 0, 0);
        check_eq("blk2_iv_sel", iv_sel, 0);
        n = 0;
        while (ph != R + 3 && n < 200) begin
            cyc(1, 1, 0, 0, 0);
            n++;
        end
        check_eq("blk2_done", digest_valid, 1);
        cyc(0, 0, 1, 0, 0);

        // clr mid-round
        cyc(1, 1, 0, 0, 0);
        run_to_idx(30);
        cyc(0, 0, 0, 1, 0);
        check_eq("clr_busy", busy, 0);
        check_eq("clr_idx", rnd_idx, 0);

        // clr coincident with accept discards the block
        cyc(1, 1, 0, 1, 0);
        check_eq("clr_accept", busy, 0);

        // asynchronous reset mid-round
        cyc(1, 0, 0, 0, 0);
        run_to_idx(40);
        RST = 1'b0;
        #1;
        ph = 0; m_first = 1'b1; m_last = 1'b0;
        check_outs(0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        cyc(1, 1, 0, 0, 0);
        check_eq("post_rst_iv_sel", iv_sel, 1);
        run_to_idle(0, 0);

`ifdef STALL_EN
        cyc(1, 1, 0, 0, 0);
        run_to_idx(20);
        repeat (5) cyc(0, 0, 0, 0, 1);
        check_eq("stall_idx", rnd_idx, 20);
        n = 0;
        while (hash_upd !== 1'b1 && n < 200) begin
            cyc(0, 0, 0, 0, 0);
            n++;
        end
        check_eq("stall_lat", n, R - 20);
        run_to_idle(0, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit s;
            s = 1'b0;
`ifdef STALL_EN
            s = ($urandom_range(0, 7) == 0);
`endif
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0, s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
